// File: rtl/svc_soc_io_periph_pkg.sv
// Shared register map and UART transmitter state encoding for the SoC I/O bank.
package svc_soc_io_periph_pkg;

  localparam logic [3:0] IO_LED         = 4'h0;
  localparam logic [3:0] IO_GPIO        = 4'h4;
  localparam logic [3:0] IO_UART_TX     = 4'h8;
  localparam logic [3:0] IO_UART_STATUS = 4'hC;

  // Word-select values; only addr[3:2] participates in the decode.
  localparam logic [1:0] SEL_LED         = IO_LED[3:2];
  localparam logic [1:0] SEL_GPIO        = IO_GPIO[3:2];
  localparam logic [1:0] SEL_UART_TX     = IO_UART_TX[3:2];
  localparam logic [1:0] SEL_UART_STATUS = IO_UART_STATUS[3:2];

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

endpackage

// File: rtl/svc_soc_io_uart_tx.sv
// 8N1 UART transmitter: one byte per accepted valid, busy for the whole frame.
module svc_soc_io_uart_tx
  import svc_soc_io_periph_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int BIT_CLKS = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W    = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

  uart_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);
  // Derived from the state register only, so it toggles cleanly on clock edges.
  assign busy    = (state != UART_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UART_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      txd   <= 1'b1;
    end else begin
      cnt <= bit_end ? '0 : cnt + CNT_W'(1);
      case (state)
        UART_IDLE: begin
          cnt <= '0;
          if (valid) begin
            shreg <= data;
            txd   <= 1'b0;
            state <= UART_START;
          end
        end
        UART_START: if (bit_end) begin
          txd   <= shreg[0];
          shreg <= shreg >> 1;
          idx   <= '0;
          state <= UART_DATA;
        end
        UART_DATA: if (bit_end) begin
          if (idx == 3'd7) begin
            txd   <= 1'b1;
            state <= UART_STOP;
          end else begin
            txd   <= shreg[0];
            shreg <= shreg >> 1;
            idx   <= idx + 3'd1;
          end
        end
        UART_STOP: if (bit_end) state <= UART_IDLE;
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/svc_soc_io_periph.sv
// Memory-mapped I/O bank on the CPU io_* port: LED, GPIO, UART TX data and status.
module svc_soc_io_periph
  import svc_soc_io_periph_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  output logic        led,
  output logic [7:0]  gpio,
  output logic        uart_tx
);

  logic [1:0] wsel, rsel;
  logic       wr_en, uart_wr, uart_busy;
  logic       unused_ok;

  assign wsel    = io_waddr[3:2];
  assign rsel    = io_raddr[3:2];
  assign wr_en   = io_wen & io_wstrb[0];
  assign uart_wr = wr_en && (wsel == SEL_UART_TX);

  assign unused_ok = ^{io_waddr[31:4], io_waddr[1:0], io_wdata[31:8],
                       io_wstrb[3:1], io_raddr[31:4], io_raddr[1:0]};

  // Read mux samples pre-edge register values, so a same-cycle write is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= 1'b0;
      gpio     <= '0;
      io_rdata <= '0;
    end else begin
      if (wr_en) begin
        case (wsel)
          SEL_LED:  led  <= io_wdata[0];
          SEL_GPIO: gpio <= io_wdata[7:0];
          default: ;
        endcase
      end
      if (io_ren) begin
        case (rsel)
          SEL_LED:         io_rdata <= {31'b0, led};
          SEL_GPIO:        io_rdata <= {24'b0, gpio};
          SEL_UART_STATUS: io_rdata <= {31'b0, uart_busy};
          default:         io_rdata <= '0;
        endcase
      end
    end
  end

  svc_soc_io_uart_tx #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) u_uart_tx (
    .clk   (clk),
    .rst   (rst),
    .valid (uart_wr),
    .data  (io_wdata[7:0]),
    .busy  (uart_busy),
    .txd   (uart_tx)
  );

endmodule

// File: tb/tb_svc_soc_io_periph.sv
// Directed + random checks of the I/O bank against a cycle-indexed behavioural model.
module tb_svc_soc_io_periph;

  localparam int CF = 1_000_000;
  localparam int BR = 100_000;
  localparam int BC = CF / BR;
  localparam int FRAME = 10 * BC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_wen = 1'b0;
  logic [31:0] io_waddr = '0;
  logic [31:0] io_wdata = '0;
  logic [3:0]  io_wstrb = '0;
  logic        io_ren = 1'b0;
  logic [31:0] io_raddr = '0;
  logic [31:0] io_rdata;
  logic        led;
  logic [7:0]  gpio;
  logic        uart_tx;

  svc_soc_io_periph #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk(clk), .rst(rst), .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
    .io_wstrb(io_wstrb), .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(io_rdata),
    .led(led), .gpio(gpio), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Model: register values plus the edge index on which the current frame started.
  logic        m_led = 1'b0;
  logic [7:0]  m_gpio = '0;
  logic [31:0] m_rdata = '0;
  int          fs = -100000;
  logic [7:0]  m_byte = '0;

  function automatic logic m_busy(input int k);
    return (k >= fs) && (k < fs + FRAME);
  endfunction

  // Line level after edge k: bit slot (k-fs)/BC, slot 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic m_tx(input int k);
    int d;
    int b;
    d = k - fs;
    if (d < 0 || d >= FRAME) return 1'b1;
    b = d / BC;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led = 1'b0; m_gpio = '0; m_rdata = '0; fs = -100000;
  endtask

  task automatic check_all();
    chk("led", {31'b0, led}, {31'b0, m_led});
    chk("gpio", {24'b0, gpio}, {24'b0, m_gpio});
    chk("uart_tx", {31'b0, uart_tx}, {31'b0, m_tx(edge_n)});
    chk("rdata", io_rdata, m_rdata);
  endtask

  task automatic do_cycle(input logic wen, input logic [31:0] wa, input logic [31:0] wd,
                          input logic [3:0] ws, input logic ren, input logic [31:0] ra);
    int k;
    io_wen = wen; io_waddr = wa; io_wdata = wd; io_wstrb = ws;
    io_ren = ren; io_raddr = ra;
    k = edge_n + 1;
    if (ren) begin
      case (ra[3:2])
        2'd0: m_rdata = {31'b0, m_led};
        2'd1: m_rdata = {24'b0, m_gpio};
        2'd2: m_rdata = '0;
        default: m_rdata = {31'b0, m_busy(k - 1)};
      endcase
    end
    if (wen && ws[0]) begin
      case (wa[3:2])
        2'd0: m_led = wd[0];
        2'd1: m_gpio = wd[7:0];
        2'd2: if (!m_busy(k - 1)) begin fs = k; m_byte = wd[7:0]; end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    check_all();
    io_wen = 1'b0; io_ren = 1'b0; io_wstrb = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    do_cycle(1'b1, a, d, 4'hF, 1'b0, '0);
  endtask

  task automatic rd(input logic [31:0] a);
    do_cycle(1'b0, '0, '0, '0, 1'b1, a);
  endtask

  // Sample mid-bit against the literal 8N1 frame; optionally issue a second (dropped) write.
  task automatic frame_check(input logic [7:0] b, input int drop_at, input logic [7:0] b2);
    int w;
    int d;
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    w = edge_n;
    for (int i = 1; i < FRAME + 15; i++) begin
      if (i == drop_at) wr(32'h8, {24'b0, b2});
      else if (i == 33 || i == FRAME + 5) rd(32'hC);
      else idle(1);
      d = edge_n - w;
      if (d % BC == 5 && d < FRAME) chk("frame_bit", {31'b0, uart_tx}, {31'b0, frame[d / BC]});
      if (d == 33) chk("status_busy", io_rdata, 32'h1);
      if (d == FRAME + 5) chk("status_idle", io_rdata, 32'h0);
    end
  endtask

  initial begin
    // 1. reset with a pending write on the bus
    io_wen = 1'b1; io_waddr = 32'h4; io_wdata = 32'hAB; io_wstrb = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    chk("rst_led", {31'b0, led}, 32'h0);
    chk("rst_gpio", {24'b0, gpio}, 32'h0);
    chk("rst_tx", {31'b0, uart_tx}, 32'h1);
    chk("rst_rdata", io_rdata, 32'h0);
    io_wen = 1'b0; io_wstrb = '0;
    rst = 1'b0;
    rd(32'h4);
    chk("post_rst_gpio_rd", io_rdata, 32'h0);

    // 2. GPIO/LED write and readback
    wr(32'h4, 32'h5A);
    wr(32'h0, 32'h1);
    chk("gpio_val", {24'b0, gpio}, 32'h5A);
    chk("led_val", {31'b0, led}, 32'h1);
    rd(32'h4);
    chk("rd_gpio", io_rdata, 32'h5A);
    rd(32'h0);
    chk("rd_led", io_rdata, 32'h1);
    idle(3);
    chk("rdata_hold", io_rdata, 32'h1);
    rd(32'h8);
    chk("rd_uart_tx_zero", io_rdata, 32'h0);

    // 3. strobe and alias decode
    do_cycle(1'b1, 32'h4, 32'hFF, 4'b1110, 1'b0, '0);
    chk("strb_ignored", {24'b0, gpio}, 32'h5A);
    do_cycle(1'b1, 32'h14, 32'hFF, 4'b0001, 1'b0, '0);
    chk("alias_write", {24'b0, gpio}, 32'hFF);
    // same-cycle read and write returns the old value
    do_cycle(1'b1, 32'h4, 32'h33, 4'h1, 1'b1, 32'h4);
    chk("rw_same_old", io_rdata, 32'hFF);
    chk("rw_same_new", {24'b0, gpio}, 32'h33);
    wr(32'hC, 32'h1);
    rd(32'hC);
    chk("status_wr_ignored", io_rdata, 32'h0);

    // 4. one full frame of 0x41
    wr(32'h8, 32'h41);
    chk("tx_start_low", {31'b0, uart_tx}, 32'h0);
    frame_check(8'h41, -1, 8'h00);

    // 5. write while busy is dropped
    wr(32'h8, 32'h41);
    frame_check(8'h41, 20, 8'h42);

    // 6. reset during data bit 3
    wr(32'h8, 32'h93);
    idle(4 * BC + 4);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_tx", {31'b0, uart_tx}, 32'h1);
    chk("midrst_gpio", {24'b0, gpio}, 32'h0);
    chk("midrst_led", {31'b0, led}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    wr(32'h8, 32'h55);
    frame_check(8'h55, -1, 8'h00);

    // random traffic against the model
    for (int i = 0; i < 600; i++)
      do_cycle(($urandom % 3) == 0, $urandom, $urandom, 4'($urandom),
               ($urandom % 2) == 0, $urandom);
    idle(FRAME + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
